mul_iterative: RTL and testbench

- Radix-2 iterative shift-add multiplier for the RV32M multiply ops: MUL, MULH, MULHSU, MULHU.
- Sits in the execute stage, directly upstream of the ALU, and feeds it result_m and flagM.
- Takes the same decoded alu_opE and operands as the ALU.
- Raises busy_m so the hazard unit stalls the pipeline while a product is being computed.

---
 rtl/mul_iterative.sv | 126 ++++++++++++
 tb/tb_mul_iterative.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mul_iterative.sv
// mul_iterative -- radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
//
// The operands are converted to magnitudes, multiplied unsigned over XLEN CALC
// cycles, and the sign is applied in FIN. The result is selected combinationally
// in FIN so that it is valid in the same cycle as flagM. It is then held in
// res_q until the next FIN or reset.
//
// Ports:
//   clk       core clock; all state updates on the rising edge
//   rst       synchronous, active-high reset
//   start     request, sampled only in IDLE
//   alu_opE   decoded op (MUL=01011, MULH=01100, MULHSU=01101, MULHU=01110)
//   SrcAE     rs1 operand
//   SrcBE     rs2 operand
//   result_m  selected product half; valid with flagM and held afterwards
//   flagM     one-cycle done pulse
//   busy_m    stall request to the hazard unit
//
// Optional feature: define MUL_EARLY_TERM_EN to leave CALC as soon as no
// multiplier bits remain.
module mul_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alu_opE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic [XLEN-1:0] result_m,
  output logic            flagM,
  output logic            busy_m
);

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state, state_nx;
  logic [4:0]          op;
  logic                neg;
  logic [2*XLEN-1:0]   mcand, acc, prod;
  logic [XLEN-1:0]     mplier, res_q, prod_sel, abs_a, abs_b;
  logic [CNT_W-1:0]    cnt;
  logic                op_ok, sign_a, sign_b, last_iter;

  assign op_ok  = (alu_opE == OP_MUL) || (alu_opE == OP_MULH) ||
                  (alu_opE == OP_MULHSU) || (alu_opE == OP_MULHU);
  assign sign_a = SrcAE[XLEN-1] && ((alu_opE == OP_MULH) || (alu_opE == OP_MULHSU));
  assign sign_b = SrcBE[XLEN-1] && (alu_opE == OP_MULH);
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  assign abs_a  = sign_a ? -SrcAE : SrcAE;
  assign abs_b  = sign_b ? -SrcBE : SrcBE;

`ifdef MUL_EARLY_TERM_EN
  // Finish once no multiplier bits remain after this cycle's shift. The bit
  // consumed this cycle is still added. A zero multiplier exits on the first
  // CALC cycle without adding, because its bit 0 is clear.
  assign last_iter = (cnt == CNT_W'(XLEN-1)) || (mplier[XLEN-1:1] == '0);
`else
  assign last_iter = (cnt == CNT_W'(XLEN-1));
`endif

  assign prod     = neg ? -acc : acc;
  assign prod_sel = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign result_m = (state == FIN) ? prod_sel : res_q;

  always_comb begin
    state_nx = state;
    busy_m   = 1'b0;
    flagM    = 1'b0;
    case (state)
      IDLE: if (start && op_ok) begin
        busy_m   = 1'b1;
        state_nx = CALC;
      end
      CALC: begin
        busy_m = 1'b1;
        if (last_iter) state_nx = FIN;
      end
      FIN: begin
        flagM    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      res_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start && op_ok) begin
          op     <= alu_opE;
          neg    <= sign_a ^ sign_b;
          mcand  <= {{XLEN{1'b0}}, abs_a};
          mplier <= abs_b;
          acc    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIN: res_q <= prod_sel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iterative.sv
// Scoreboard bench for mul_iterative: the driver pushes expected results and
// the cycle in which flagM is due; the monitor pops on every flagM.
module tb_mul_iterative;

  localparam logic [4:0] MUL = 5'b01011, MULH = 5'b01100,
                         MULHSU = 5'b01101, MULHU = 5'b01110, ADD = 5'b00000;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [4:0]  alu_opE = '0;
  logic [31:0] SrcAE = '0, SrcBE = '0, result_m;
  logic        flagM, busy_m;

  mul_iterative #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_opE(alu_opE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .result_m(result_m),
    .flagM(flagM), .busy_m(busy_m)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, res;
    int          lat_et;
  } vec_t;

  exp_t q[$];
  int   vecs = 0, errs = 0;

  vec_t vt[9] = '{
    '{MUL,    32'd7,        32'd6,        32'd42,         4},
    '{MULH,   32'h80000000, 32'h80000000, 32'h40000000,  33},
    '{MUL,    32'hFFFFFFFF, 32'd5,        32'hFFFFFFFB,   4},
    '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,  33},
    '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  33},
    '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  33},
    '{MUL,    32'd5,        32'd0,        32'd0,          2},
    '{MUL,    32'd3,        32'd4,        32'd12,         4},
    '{MULH,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF,   4}
  };

  // Monitor: every flagM must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && flagM) begin
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL spurious_flagM cyc=%0d result_m=%h required no flagM", cyc, result_m);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (result_m !== e.res || cyc != e.due) begin
          errs++;
          $display("FAIL result cyc=%0d result_m=%h required %h at cyc %0d",
                   cyc, result_m, e.res, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  // Presents one request for a single cycle and pushes its expectation.
  task automatic issue(input vec_t v);
    exp_t e;
    int   lat;
`ifdef MUL_EARLY_TERM_EN
    lat = v.lat_et;
`else
    lat = 33;
`endif
    @(posedge clk); #1;
    start = 1'b1; alu_opE = v.op; SrcAE = v.a; SrcBE = v.b;
    e.res = v.res; e.due = cyc + lat;
    q.push_back(e);
    @(negedge clk);
    check("busy_on_start", {31'd0, busy_m}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vecs++; errs++;
      $display("FAIL timeout outstanding=%0d required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_flag();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!flagM && n < 80);
    if (!flagM) begin
      vecs++; errs++;
      $display("FAIL flag_timeout flagM=0 required 1");
    end
  endtask

  initial begin
    int fl;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_result", result_m, 32'd0);
    check("reset_flag", {31'd0, flagM}, 32'd0);
    check("reset_busy", {31'd0, busy_m}, 32'd0);

    // Directed vectors, each with a full drain.
    foreach (vt[i]) begin
      issue(vt[i]);
      wait_done();
    end

    // A non-multiply op must be ignored.
    @(posedge clk); #1;
    start = 1'b1; alu_opE = ADD; SrcAE = 32'd9; SrcBE = 32'd9;
    @(negedge clk);
    check("add_busy", {31'd0, busy_m}, 32'd0);
    fl = 0;
    repeat (40) begin
      @(negedge clk);
      if (flagM) fl++;
    end
    check("add_no_flag", fl, 0);
    @(posedge clk); #1 start = 1'b0;

    // Re-asserting start during CALC must not start a second op.
    issue(vt[0]);
    start = 1'b1; alu_opE = MUL; SrcAE = 32'd100; SrcBE = 32'd100;
`ifdef MUL_EARLY_TERM_EN
    @(negedge clk);
`else
    repeat (3) @(negedge clk);
`endif
    check("busy_in_calc", {31'd0, busy_m}, 32'd1);
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Back-to-back: the second op starts in the IDLE cycle after flagM.
    issue(vt[1]);
    wait_flag();
    issue(vt[7]);
    wait_done();
    check("b2b_hold", result_m, 32'd12);

    // A reset mid-operation aborts the op, and no flagM follows.
    issue(vt[4]);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_result", result_m, 32'd0);
    check("abort_flag", {31'd0, flagM}, 32'd0);
    check("abort_busy", {31'd0, busy_m}, 32'd0);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
